// File: rtl/mem_req_queue_pkg.sv
// Shared request types and default sizing for the memory request queue.
package global_defs;

  localparam int unsigned DEPTH_DEF      = 16;
  localparam int unsigned AGE_W_DEF      = 8;
  localparam int unsigned STARVE_AGE_DEF = 200;

  typedef enum logic [1:0] {
    OpRead   = 2'd0,
    OpWrite  = 2'd1,
    OpFetch  = 2'd2,
    OpAtomic = 2'd3
  } op_e;

  // One parsed memory request: arrival time, issuing core, operation, address.
  typedef struct packed {
    logic [15:0] req_time;
    logic [3:0]  core;
    op_e         operation;
    logic [31:0] address;
  } parser_out_struct_t;

  typedef logic [AGE_W_DEF-1:0] age_counter_t;

endpackage

// File: rtl/mem_req_queue_starve_finder.sv
// Priority encoder: lowest valid position whose age has reached the starvation threshold.
module starve_finder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AGE_W      = 8,
  parameter int unsigned STARVE_AGE = 200
) (
  input  logic [DEPTH-1:0][AGE_W-1:0] ages_i,
  input  logic [DEPTH-1:0]            valid_i,
  output logic                        starve_o,
  output logic [$clog2(DEPTH)-1:0]    starve_idx_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  // Scan from the top down so the lowest matching position wins.
  always_comb begin
    starve_o     = 1'b0;
    starve_idx_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_i[i] && (ages_i[i] >= AGE_W'(STARVE_AGE))) begin
        starve_o     = 1'b1;
        starve_idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_req_queue.sv
// Compacted, age-tracking request queue with arbitrary-position removal.
module mem_req_queue
  import global_defs::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned AGE_W      = AGE_W_DEF,
  parameter int unsigned STARVE_AGE = STARVE_AGE_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  input  parser_out_struct_t                  in_req,
  output logic                                in_ready,
  input  logic                                deq_en,
  input  logic [$clog2(DEPTH)-1:0]            deq_idx,
  output parser_out_struct_t [DEPTH-1:0]      entries,
  output logic [DEPTH-1:0][AGE_W-1:0]         ages,
  output logic [DEPTH-1:0]                    valid_mask,
  output logic [$clog2(DEPTH):0]              count,
  output logic                                full,
  output logic                                empty,
  output logic                                starve,
  output logic [$clog2(DEPTH)-1:0]            starve_idx,
  output logic                                deq_err
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  parser_out_struct_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0][AGE_W-1:0]    age_q, age_d;
  logic [CntW-1:0]                cnt_q, cnt_d, cnt_after;
  logic                           err_q, err_d;
  logic                           deq_ok, enq_ok;

  // Status flags derived from the registered occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_mask[i] = CntW'(i) < cnt_q;
    end
    full     = (cnt_q == CntW'(DEPTH));
    empty    = (cnt_q == '0);
    in_ready = !full;
    deq_ok   = deq_en && ({1'b0, deq_idx} < cnt_q);
    // A legal removal frees a slot before the insert, so a full queue still takes the request.
    enq_ok   = in_valid && (!full || deq_ok);
  end

  // Next state: age valid entries, then remove, then append at the post-removal tail.
  always_comb begin
    ent_d     = ent_q;
    age_d     = age_q;
    err_d     = deq_en && !deq_ok;
    cnt_after = cnt_q - CntW'(deq_ok);

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_mask[i] && (age_q[i] != '1)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end

    // In-place shift reads i+1 before it is overwritten on the next iteration.
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (deq_ok && (i >= int'(deq_idx))) begin
        ent_d[i] = ent_d[i+1];
        age_d[i] = age_d[i+1];
      end
    end
    if (deq_ok) begin
      ent_d[DEPTH-1] = '0;
      age_d[DEPTH-1] = '0;
    end

    if (enq_ok) begin
      ent_d[cnt_after[IdxW-1:0]] = in_req;
      age_d[cnt_after[IdxW-1:0]] = '0;
    end
    cnt_d = cnt_after + CntW'(enq_ok);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q <= '0;
      age_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      age_q <= age_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign entries = ent_q;
  assign ages    = age_q;
  assign count   = cnt_q;
  assign deq_err = err_q;

  starve_finder #(
    .DEPTH      (DEPTH),
    .AGE_W      (AGE_W),
    .STARVE_AGE (STARVE_AGE)
  ) u_starve_finder (
    .ages_i       (age_q),
    .valid_i      (valid_mask),
    .starve_o     (starve),
    .starve_idx_o (starve_idx)
  );

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed self-checking bench for mem_req_queue with default sizing.
module tb_mem_req_queue;
  import global_defs::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AGE_W = 8;

  logic                           clk;
  logic                           rst_n;
  logic                           in_valid;
  parser_out_struct_t             in_req;
  logic                           in_ready;
  logic                           deq_en;
  logic [3:0]                     deq_idx;
  parser_out_struct_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0][AGE_W-1:0]    ages;
  logic [DEPTH-1:0]               valid_mask;
  logic [4:0]                     count;
  logic                           full;
  logic                           empty;
  logic                           starve;
  logic [3:0]                     starve_idx;
  logic                           deq_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_req_queue #(
    .DEPTH      (16),
    .AGE_W      (8),
    .STARVE_AGE (200)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_req     (in_req),
    .in_ready   (in_ready),
    .deq_en     (deq_en),
    .deq_idx    (deq_idx),
    .entries    (entries),
    .ages       (ages),
    .valid_mask (valid_mask),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .starve     (starve),
    .starve_idx (starve_idx),
    .deq_err    (deq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic parser_out_struct_t mk(input int k);
    parser_out_struct_t r;
    r.req_time  = 16'(16'h1000 + k);
    r.core      = 4'(k);
    r.operation = op_e'(2'(k));
    r.address   = 32'(32'hA000_0000 + k * 16);
    return r;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_req   = '0;
    deq_en   = 1'b0;
    deq_idx  = '0;
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_mask", 64'(valid_mask), 64'd0);
    check("rst_starve", 64'(starve), 64'd0);
    check("rst_deq_err", 64'(deq_err), 64'd0);
    check("rst_age0", 64'(ages[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Three back-to-back enqueues.
    in_valid = 1'b1;
    in_req = mk(1); tick();
    in_req = mk(2); tick();
    in_req = mk(3); tick();
    in_valid = 1'b0;
    check("abc_count", 64'(count), 64'd3);
    check("abc_e0", 64'(entries[0]), 64'(mk(1)));
    check("abc_e1", 64'(entries[1]), 64'(mk(2)));
    check("abc_e2", 64'(entries[2]), 64'(mk(3)));
    check("abc_age0", 64'(ages[0]), 64'd2);
    check("abc_age1", 64'(ages[1]), 64'd1);
    check("abc_age2", 64'(ages[2]), 64'd0);
    check("abc_mask", 64'(valid_mask), 64'h7);

    // Add D, then remove B from the middle.
    in_valid = 1'b1; in_req = mk(4); tick();
    in_valid = 1'b0;
    check("abcd_count", 64'(count), 64'd4);
    deq_en = 1'b1; deq_idx = 4'd1; tick();
    deq_en = 1'b0;
    check("mid_count", 64'(count), 64'd3);
    check("mid_e0", 64'(entries[0]), 64'(mk(1)));
    check("mid_e1", 64'(entries[1]), 64'(mk(3)));
    check("mid_e2", 64'(entries[2]), 64'(mk(4)));
    check("mid_e3_clr", 64'(entries[3]), 64'd0);
    check("mid_age0", 64'(ages[0]), 64'd4);
    check("mid_age1", 64'(ages[1]), 64'd2);
    check("mid_age2", 64'(ages[2]), 64'd1);
    check("mid_age3_clr", 64'(ages[3]), 64'd0);
    check("mid_no_err", 64'(deq_err), 64'd0);

    // Illegal removal alongside a legal enqueue.
    deq_en = 1'b1; deq_idx = 4'd5; in_valid = 1'b1; in_req = mk(5); tick();
    deq_en = 1'b0; in_valid = 1'b0;
    check("ill_err", 64'(deq_err), 64'd1);
    check("ill_count", 64'(count), 64'd4);
    check("ill_e1", 64'(entries[1]), 64'(mk(3)));
    check("ill_e3", 64'(entries[3]), 64'(mk(5)));
    tick();
    check("ill_err_pulse", 64'(deq_err), 64'd0);

    // Asynchronous reset mid-operation, then first enqueue lands at 0.
    do_reset();
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_e0", 64'(entries[0]), 64'd0);
    in_valid = 1'b1; in_req = mk(6); tick();
    in_valid = 1'b0;
    check("mrst_enq_e0", 64'(entries[0]), 64'(mk(6)));
    check("mrst_enq_count", 64'(count), 64'd1);

    // Dequeue from an empty queue.
    do_reset();
    deq_en = 1'b1; deq_idx = 4'd0; tick();
    deq_en = 1'b0;
    check("empty_deq_err", 64'(deq_err), 64'd1);
    check("empty_deq_count", 64'(count), 64'd0);
    tick();
    check("empty_deq_pulse", 64'(deq_err), 64'd0);

    // Fill to DEPTH with in_valid held, then present one more.
    do_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_req = mk(100 + k);
      tick();
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(in_ready), 64'd0);
    check("fill_count", 64'(count), 64'd16);
    in_req = mk(200); tick();
    in_valid = 1'b0;
    check("over_count", 64'(count), 64'd16);
    check("over_e15", 64'(entries[15]), 64'(mk(115)));
    check("over_age0", 64'(ages[0]), 64'd16);
    check("over_age15", 64'(ages[15]), 64'd1);

    // Full queue: enqueue and remove the oldest in the same cycle.
    in_valid = 1'b1; in_req = mk(7); deq_en = 1'b1; deq_idx = 4'd0; tick();
    in_valid = 1'b0; deq_en = 1'b0;
    check("swap_count", 64'(count), 64'd16);
    check("swap_e15", 64'(entries[15]), 64'(mk(7)));
    check("swap_age15", 64'(ages[15]), 64'd0);
    check("swap_e0", 64'(entries[0]), 64'(mk(101)));
    check("swap_age0", 64'(ages[0]), 64'd16);

    // Starvation threshold and age saturation on a single entry.
    do_reset();
    in_valid = 1'b1; in_req = mk(8); tick();
    in_valid = 1'b0;
    repeat (199) tick();
    check("starve_below_age", 64'(ages[0]), 64'd199);
    check("starve_below", 64'(starve), 64'd0);
    tick();
    check("starve_at", 64'(starve), 64'd1);
    check("starve_idx", 64'(starve_idx), 64'd0);
    repeat (55) tick();
    check("sat_255", 64'(ages[0]), 64'd255);
    tick();
    check("sat_hold", 64'(ages[0]), 64'd255);
    check("sat_starve", 64'(starve), 64'd1);
    check("sat_age1_idle", 64'(ages[1]), 64'd0);

    // Young entry behind a starving one; remove the old one.
    in_valid = 1'b1; in_req = mk(9); tick();
    in_valid = 1'b0;
    deq_en = 1'b1; deq_idx = 4'd0; tick();
    deq_en = 1'b0;
    check("young_count", 64'(count), 64'd1);
    check("young_e0", 64'(entries[0]), 64'(mk(9)));
    check("young_age0", 64'(ages[0]), 64'd1);
    check("young_starve", 64'(starve), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
